// File: rtl/int_src_pkg.sv
// int_src_pkg: shared types and constants for the interrupt request source
package int_src_pkg;
  localparam int CNT_W = 8;
  localparam int NUM_LINES = 4;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEBOUNCE  = 3'd1,
    ISSUE     = 3'd2,
    WAIT_PEND = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;
endpackage

// File: rtl/int_line_src.sv
// int_line_src: one request line (sync, debounce, issue/track FSM); INT_SRC_STATS_EN adds drop_count
module int_line_src
  import int_src_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic int_waiting,
  output logic ir,
`ifdef INT_SRC_STATS_EN
  output logic [CNT_W-1:0] drop_count,
`endif
  output logic busy
);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_MAX = CNT_W'(ACK_TIMEOUT - 1);
  logic s1, s2;
  logic [CNT_W-1:0] cnt, cnt_inc;
  state_t state;
  assign cnt_inc = cnt + CNT_W'(cnt != '1);
  assign busy = state != IDLE;
  // two-flop synchronizer for the asynchronous raw line
  always_ff @(posedge clk or posedge rst)
    if (rst) {s2, s1} <= 2'b00;
    else {s2, s1} <= {s1, raw};
  // per-line FSM; ir is set on entry to ISSUE so it is high only for that cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ir <= 1'b0;
    end else begin
      ir <= 1'b0;
      case (state)
        IDLE: if (s2) begin
          state <= DEBOUNCE;
          cnt <= '0;
        end
        DEBOUNCE: if (!s2) state <= IDLE;
          else if (cnt == DB_MAX) begin
            state <= ISSUE;
            ir <= 1'b1;
          end else cnt <= cnt_inc;
        ISSUE: begin
          state <= WAIT_PEND;
          cnt <= '0;
        end
        WAIT_PEND: if (int_waiting) state <= WAIT_DONE;
          else if (cnt == ACK_MAX) begin
            state <= ISSUE;
            ir <= 1'b1;
          end else cnt <= cnt_inc;
        WAIT_DONE: if (!int_waiting && !s2) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef INT_SRC_STATS_EN
  logic s3;
  // count presses swallowed while a request is outstanding, saturating
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s3 <= 1'b0;
      drop_count <= '0;
    end else begin
      s3 <= s2;
      drop_count <= (s2 && !s3 && state inside {ISSUE, WAIT_PEND, WAIT_DONE} && drop_count != '1)
                    ? drop_count + 1'b1 : drop_count;
    end
`endif
endmodule

// File: rtl/int_request_source.sv
// int_request_source: four independent debounced IRn/IntWaitingn request lines; INT_SRC_STATS_EN adds drop counters
module int_request_source
  import int_src_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_LINES-1:0] irq_raw,
  input  logic IntWaiting0,
  input  logic IntWaiting1,
  input  logic IntWaiting2,
  input  logic IntWaiting3,
  output logic IR0,
  output logic IR1,
  output logic IR2,
  output logic IR3,
`ifdef INT_SRC_STATS_EN
  output logic [CNT_W-1:0] drop_count0,
  output logic [CNT_W-1:0] drop_count1,
  output logic [CNT_W-1:0] drop_count2,
  output logic [CNT_W-1:0] drop_count3,
`endif
  output logic [NUM_LINES-1:0] line_busy
);
  logic [NUM_LINES-1:0] iw, ir;
  assign iw = {IntWaiting3, IntWaiting2, IntWaiting1, IntWaiting0};
  assign {IR3, IR2, IR1, IR0} = ir;
`ifdef INT_SRC_STATS_EN
  logic [CNT_W-1:0] dc [NUM_LINES];
  assign drop_count0 = dc[0];
  assign drop_count1 = dc[1];
  assign drop_count2 = dc[2];
  assign drop_count3 = dc[3];
`endif
  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    int_line_src #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_line (
      .clk(clk),
      .rst(rst),
      .raw(irq_raw[i]),
      .int_waiting(iw[i]),
      .ir(ir[i]),
`ifdef INT_SRC_STATS_EN
      .drop_count(dc[i]),
`endif
      .busy(line_busy[i])
    );
  end
endmodule

// File: tb/tb_int_request_source.sv
// tb_int_request_source: directed self-checking bench for int_request_source
module tb_int_request_source;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] raw, iw, busy, ir;
  logic ir0, ir1, ir2, ir3;
  int tests = 0, fails = 0, d, p;
`ifdef INT_SRC_STATS_EN
  logic [7:0] dc0, dc1, dc2, dc3;
`endif
  assign ir = {ir3, ir2, ir1, ir0};
  int_request_source #(.DEBOUNCE_CYCLES(4), .ACK_TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .irq_raw(raw),
    .IntWaiting0(iw[0]),
    .IntWaiting1(iw[1]),
    .IntWaiting2(iw[2]),
    .IntWaiting3(iw[3]),
    .IR0(ir0),
    .IR1(ir1),
    .IR2(ir2),
    .IR3(ir3),
`ifdef INT_SRC_STATS_EN
    .drop_count0(dc0),
    .drop_count1(dc1),
    .drop_count2(dc2),
    .drop_count3(dc3),
`endif
    .line_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input int obs, input int exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask
  task automatic wait_ir(input int n, output int dd);
    dd = 0;
    while (dd < 30) begin
      step(1);
      dd++;
      if (ir[n]) break;
    end
  endtask
  task automatic count_ir(input int n, input int cyc, output int pp);
    pp = 0;
    repeat (cyc) begin
      step(1);
      if (ir[n]) pp++;
    end
  endtask
  initial begin
    rst = 1'b1;
    raw = '0;
    iw = '0;
    step(2);
    chk("reset_ir", ir, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    step(1);
    raw[0] = 1'b1;
    step(2);
    chk("l0_busy_e2", busy[0], 0);
    step(1);
    chk("l0_busy_e3", busy[0], 1);
    step(3);
    chk("l0_ir_e6", ir, 0);
    step(1);
    chk("l0_ir_e7", ir, 4'b0001);
    step(1);
    chk("l0_ir_e8", ir, 0);
    iw[0] = 1'b1;
    step(1);
    raw[0] = 1'b0;
    iw[0] = 1'b0;
    step(4);
    chk("l0_idle", busy[0], 0);
    raw[1] = 1'b1;
    step(3);
    chk("l1_debounce", busy[1], 1);
    raw[1] = 1'b0;
    count_ir(1, 10, p);
    chk("l1_glitch_pulses", p, 0);
    chk("l1_idle", busy[1], 0);
    raw[2] = 1'b1;
    wait_ir(2, d);
    chk("l2_latency", d, 7);
    wait_ir(2, d);
    chk("l2_reissue1", d, 9);
    wait_ir(2, d);
    chk("l2_reissue2", d, 9);
    step(1);
    iw[2] = 1'b1;
    count_ir(2, 20, p);
    chk("l2_after_ack", p, 0);
    chk("l2_wait_done", busy[2], 1);
    raw[2] = 1'b0;
    iw[2] = 1'b0;
    step(4);
    chk("l2_idle", busy[2], 0);
    raw[3] = 1'b1;
    wait_ir(3, d);
    chk("l3_latency", d, 7);
    step(1);
    iw[3] = 1'b1;
    step(2);
    iw[3] = 1'b0;
    count_ir(3, 20, p);
    chk("l3_held_no_refire", p, 0);
    chk("l3_busy_held", busy[3], 1);
    raw[3] = 1'b0;
    step(4);
    chk("l3_idle", busy[3], 0);
    raw[3] = 1'b1;
    wait_ir(3, d);
    chk("l3_refire", d, 7);
    step(1);
    iw[3] = 1'b1;
    raw[3] = 1'b0;
    step(1);
    iw[3] = 1'b0;
    step(4);
    chk("l3_idle2", busy[3], 0);
    chk("all_idle", busy, 0);
    raw = 4'hF;
    step(7);
    chk("all_ir", ir, 4'hF);
    step(1);
    chk("all_wait_pend", busy, 4'hF);
    #2 rst = 1'b1;
    raw = '0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ir", ir, 0);
    step(2);
    rst = 1'b0;
    d = 0;
    for (int i = 0; i < 4; i++) begin
      count_ir(i, 4, p);
      d += p;
    end
    chk("post_rst_pulses", d, 0);
    chk("post_rst_busy", busy, 0);
`ifdef INT_SRC_STATS_EN
    raw[0] = 1'b1;
    wait_ir(0, d);
    chk("st_latency", d, 7);
    step(1);
    iw[0] = 1'b1;
    step(2);
    chk("st_drop0", dc0, 0);
    repeat (3) begin
      raw[0] = 1'b0;
      step(3);
      raw[0] = 1'b1;
      step(3);
    end
    step(3);
    chk("st_drop3", dc0, 3);
    repeat (300) begin
      raw[0] = 1'b0;
      step(2);
      raw[0] = 1'b1;
      step(2);
    end
    step(3);
    chk("st_drop_sat", dc0, 255);
    chk("st_drop1_untouched", dc1, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
